// File: rtl/lm_acc_if.sv
// Handshake bundle between the log multiplier, the accumulator and its consumer.
// Carries the product beat stream in and the vector result stream out.
// The slave modport is the accumulator's view; the master modport is the surrounding logic's view.
interface lm_acc_if #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [LEN_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_sat
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_sat
    );
endinterface

// File: rtl/lm_acc.sv
// Saturating vector accumulator behind the Mitchell log multiplier; one product beat per cycle.
// Latency: result valid the cycle after the beat flagged last is accepted; one bubble cycle per vector.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_ready.
module lm_acc #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    lm_acc_if.slave  bus
);

    typedef enum logic {ACC, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] count;
    logic             sat;
    logic             in_ready_q;
    logic             out_valid_q;

    // One extra carry bit tells whether the true sum left the accumulator range.
    logic [ACC_W:0]   sum_full;
    logic             accept;

    assign accept   = bus.in_valid && in_ready_q;
    assign sum_full = {1'b0, acc} + (ACC_W+1)'(bus.in_data);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.out_count = count;
    assign bus.out_sat   = sat;

    // Control FSM plus accumulator/counter registers; handshake outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACC;
            acc         <= '0;
            count       <= '0;
            sat         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        if (sum_full[ACC_W]) begin
                            acc <= '1;
                            sat <= 1'b1;
                        end else begin
                            acc <= sum_full[ACC_W-1:0];
                        end
                        // Beat count pins at its maximum rather than wrapping.
                        if (count != '1) begin
                            count <= count + LEN_W'(1);
                        end
                        if (bus.in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= ACC;
                        acc         <= '0;
                        count       <= '0;
                        sat         <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lm_acc.md
# lm_acc

Streaming accumulator directly downstream of the 16x16 Mitchell log multiplier: it consumes the multiplier's 32-bit unsigned approximate products one per cycle over a valid/ready handshake, sums a vector of them terminated by a last flag, and presents the saturating sum with a beat count on an output handshake. It supplies the registered, flow-controlled stage the combinational multiplier lacks, turning it into an approximate dot-product / MAC datapath.

## Interface
- W, 32, product width (2*n of the multiplier)
- ACC_W, 40, accumulator width; must be >= W
- LEN_W, 8, beat-counter width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  W  unsigned product from the multiplier
- in_last  input  1  beat is the final one of the vector
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  ACC_W  vector sum (unsigned, saturating)
- out_count  output  LEN_W  beats in vector (saturating)
- out_sat  output  1  sum clipped at 2^ACC_W-1

## Operation
- Two states: ACC, DONE. Reset enters ACC with acc=0, count=0, sat=0.
- ACC: in_ready=1, out_valid=0. On accept (in_valid&in_ready): acc <= acc + zero-extended in_data; if true sum >= 2^ACC_W, acc <= 2^ACC_W-1 and sat <= 1 (sticky for the vector). count <= count+1, holding at 2^LEN_W-1.
- Accept with in_last=1: the same update is made and the state moves to DONE; out_data/out_count/out_sat then reflect the sum including that beat.
- DONE: in_ready=0, out_valid=1. out_data, out_count and out_sat are stable while out_ready=0. On out_ready=1: acc, count and sat clear; return to ACC.
- in_data and in_last are ignored when in_valid=0. in_valid held high in DONE is not accepted and must be held by the producer.
- out_data/out_count/out_sat are driven directly from the acc/count/sat registers (out_data=acc, out_count=count, out_sat=sat); they are don't-care when out_valid=0.
- Single-beat vector (in_last on first beat): out_data=in_data, out_count=1.
- rst mid-vector or mid-DONE: partial sum discarded, result lost, ACC with all registers cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_count=0, out_sat=0.
- Throughput: 1 beat/cycle within a vector; at least 1 bubble cycle per vector (the DONE cycle).
- Latency: out_valid rises on the clock edge that accepts the last beat (visible the following cycle).
- Earliest next accept: the cycle after the out_valid&out_ready handshake.
- in_ready is a pure function of state; there is no combinational path from out_ready to in_ready.
- The multiplier stays combinational in front of this block; in_data arrives with its full combinational delay. in_data is registered only inside the adder/acc path.

## Test plan
- Reset, then beats 15, 100, 7 (last on 7), out_ready=1 -> out_valid one cycle after the last accept, out_data=122, out_count=3, out_sat=0; in_ready low for exactly that cycle.
- Single beat 0xFFFF_FFFF with last -> out_data=0x00_FFFF_FFFF, out_count=1; next vector 1 (last) -> out_data=1 (cleared between vectors).
- Back-pressure: finish vector 5, 6 (last), hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out_data=11 stable, no beat accepted; raise out_ready -> handshake, held beat accepted the next cycle.
- Saturation with ACC_W=33: beats 0xFFFF_FFFF x3 (last on 3rd) -> out_data=0x1_FFFF_FFFF, out_sat=1, out_count=3; following vector 2 (last) -> out_sat=0.
- Count saturation with LEN_W=2: 5 beats of 1 -> out_count=3, out_data=5.
- Assert rst after two beats (10, 20) of a vector, release, send 4 (last) -> out_data=4, out_count=1; rst during DONE drops out_valid immediately (asynchronously).
